fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter XLEN, default 32, PC width in bits.
REQ-002 Parameter IW, default 30, stored instruction width (instr[31:2]).
REQ-003 Parameter DEPTH, default 16, entry count; power of two, >= 4.
REQ-004 Parameter PUSH_W, default 2, max entries written per cycle (1 or 2).
REQ-005 Parameter POP_W, default 2, max entries read per cycle (1 or 2).
REQ-006 Parameter AFULL_TH, default DEPTH-2, almost-full threshold.
REQ-007 clock  in  1  clock, rising edge.
REQ-008 resetn  in  1  reset, asynchronous, active-low.
REQ-009 flush  in  1  synchronous discard of all entries.
REQ-010 in_cnt  in  2  entries offered this cycle, 0..PUSH_W.
REQ-011 in_instr  in  PUSH_W*IW  offered instructions, slot 0 oldest, LSB-first.
REQ-012 in_pc  in  PUSH_W*XLEN  PCs of offered instructions, slot 0 oldest.
REQ-013 in_ready  out  1  free slots >= PUSH_W.
REQ-014 pop_cnt  in  2  entries consumed this cycle, 0..POP_W.
REQ-015 out_valid  out  POP_W  thermometer; bit i = entry i present.
REQ-016 out_instr  out  POP_W*IW  head entries, slot 0 oldest.
REQ-017 out_pc  out  POP_W*XLEN  PCs of head entries.
REQ-018 count  out  $clog2(DEPTH)+1  occupied entries.
REQ-019 empty, full, almost_full  out  1 each  count==0, count==DEPTH, count>=AFULL_TH.

Function
REQ-020 Circular storage; rd/wr pointers $clog2(DEPTH) bits, wrap modulo DEPTH with no special casing.
REQ-021 Push all-or-nothing: group of in_cnt accepted iff in_cnt <= DEPTH - count (pre-pop count); otherwise nothing written, no error state.
REQ-022 Accepted slot k written at wr_ptr+k; wr_ptr += in_cnt.
REQ-023 Show-ahead read: out_* combinational from rd_ptr+i, zero latency.
REQ-024 out_valid[i] = (count > i); out_instr/out_pc slot i driven 0 when out_valid[i]=0.
REQ-025 Effective pop = min(pop_cnt, count, POP_W); over-pop clipped, never underflows.
REQ-026 Next count = count + accepted - effective pop; same-cycle push and pop both honoured.
REQ-027 Push into a full queue with a same-cycle pop is rejected (pre-pop check, REQ-021).
REQ-028 flush priority: pointers and count cleared next edge; same-cycle push and pop ignored.
REQ-029 Order preserved: entries leave in exact push order across wrap-around.
REQ-030 count, empty, full, almost_full, in_ready derived from registered count only.

Reset
REQ-031 resetn low: rd_ptr=0, wr_ptr=0, count=0 immediately, independent of clock.
REQ-032 During reset: empty=1, full=0, almost_full=0, in_ready=1, out_valid=0, out_instr=0, out_pc=0.
REQ-033 Storage array not reset; contents unobservable per REQ-024.
REQ-034 Reset asserted mid-push/pop discards all entries; first accepted push after release lands at index 0.

Configuration
REQ-035 Macro FETCH_QUEUE_BYPASS_EN enables empty-queue bypass.
REQ-036 Defined: when count==0, accepted in_* slots appear on out_* same cycle (out_valid[i] = i < in_cnt); entries popped that cycle are not written, wr_ptr and rd_ptr both advance by the popped amount, remainder stored.
REQ-037 Not defined: pushed entries visible on out_* earliest one cycle after push; behaviour per REQ-020..REQ-030 only.
REQ-038 Bypass never applies when flush=1 or count>0.

Verification
REQ-039 Reset, then in_cnt=2 (PC 0x100,0x104), pop 0 -> next cycle count=2, out_valid=2'b11, out_pc={0x104,0x100}.
REQ-040 Fill 16 entries, then in_cnt=1 with pop_cnt=1 -> push rejected, count=15, full=0, in_ready=0.
REQ-041 count=1, pop_cnt=2 -> effective pop 1, count=0, empty=1, no pointer corruption on next push.
REQ-042 40 single pushes/pops with random stalls (PC 0x0 step 4) -> 40 outputs in order across 2+ wraps.
REQ-043 count=7, flush=1 with in_cnt=2, pop_cnt=2 -> next cycle count=0, empty=1, out_valid=0.
REQ-044 FETCH_QUEUE_BYPASS_EN, empty, in_cnt=2 (0x200,0x204), pop_cnt=1 -> same cycle out_pc[0]=0x200; next cycle count=1, out_pc[0]=0x204.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction fetch queue with multi-entry push and pop.
//   Up to PUSH_W instructions are written per cycle (all-or-nothing) and up
//   to POP_W head entries are presented show-ahead on out_* every cycle.
//   Build option: define FETCH_QUEUE_BYPASS_EN to forward pushed entries
//   straight to out_* in the same cycle while the queue is empty.
// Ports:
//   clock, resetn (async, active-low), flush (sync discard of all entries)
//   in_cnt/in_instr/in_pc : offered group, slot 0 oldest; in_ready = room for PUSH_W
//   pop_cnt               : entries consumed this cycle (clipped to what is shown)
//   out_valid/out_instr/out_pc : head entries, thermometer valid, slot 0 oldest
//   count/empty/full/almost_full : occupancy from the registered count
module fetch_queue #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned IW       = 30,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned PUSH_W   = 2,
  parameter int unsigned POP_W    = 2,
  parameter int unsigned AFULL_TH = DEPTH - 2
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic [1:0]                 in_cnt,
  input  logic [PUSH_W*IW-1:0]       in_instr,
  input  logic [PUSH_W*XLEN-1:0]     in_pc,
  output logic                       in_ready,
  input  logic [1:0]                 pop_cnt,
  output logic [POP_W-1:0]           out_valid,
  output logic [POP_W*IW-1:0]        out_instr,
  output logic [POP_W*XLEN-1:0]      out_pc,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [IW-1:0]   mem_instr [DEPTH];
  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   free, take, avail, pop_eff, skip;
  logic            accept, bypass;

  assign free        = CW'(DEPTH) - count;
  assign in_ready    = free >= CW'(PUSH_W);
  assign empty       = count == '0;
  assign full        = count == CW'(DEPTH);
  assign almost_full = count >= CW'(AFULL_TH);

  // Acceptance uses the pre-pop occupancy, so a full queue rejects a push
  // even when a pop frees room in the same cycle.
  assign accept = (in_cnt <= 2'(PUSH_W)) && (CW'(in_cnt) <= free);
  assign take   = accept ? CW'(in_cnt) : '0;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = (count == '0) && !flush;
`else
  assign bypass = 1'b0;
`endif

  // While bypassing, the visible entries are the incoming ones; popped
  // incoming slots are never written and both pointers step over them.
  assign avail = bypass ? take : count;
  assign skip  = bypass ? pop_eff : '0;

  always_comb begin
    pop_eff = CW'(pop_cnt);
    if (pop_eff > CW'(POP_W)) pop_eff = CW'(POP_W);
    if (pop_eff > avail)      pop_eff = avail;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(take);
      rd_ptr <= rd_ptr + PW'(pop_eff);
      count  <= count + take - pop_eff;
    end
  end

  // Storage is deliberately not reset; invalid slots are masked to zero.
  always_ff @(posedge clock) begin
    if (!flush) begin
      for (int unsigned k = 0; k < PUSH_W; k++) begin
        if (CW'(k) < take && CW'(k) >= skip) begin
          mem_instr[wr_ptr + PW'(k)] <= in_instr[k*IW +: IW];
          mem_pc[wr_ptr + PW'(k)]    <= in_pc[k*XLEN +: XLEN];
        end
      end
    end
  end

  for (genvar i = 0; i < POP_W; i++) begin : g_out
    logic [PW-1:0]   idx;
    logic            slot_v;
    logic [IW-1:0]   byp_instr;
    logic [XLEN-1:0] byp_pc;

    assign idx    = rd_ptr + PW'(i);
    assign slot_v = bypass ? (CW'(i) < take) : (CW'(i) < count);

    if (i < PUSH_W) begin : g_byp
      assign byp_instr = in_instr[i*IW +: IW];
      assign byp_pc    = in_pc[i*XLEN +: XLEN];
    end else begin : g_nobyp
      assign byp_instr = '0;
      assign byp_pc    = '0;
    end

    assign out_valid[i]             = slot_v;
    assign out_instr[i*IW +: IW]    = slot_v ? (bypass ? byp_instr : mem_instr[idx]) : '0;
    assign out_pc[i*XLEN +: XLEN]   = slot_v ? (bypass ? byp_pc : mem_pc[idx]) : '0;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue (default parameters).
//   Expected entries are queued when an accepted push is driven and popped
//   and compared against out_* when the DUT presents and consumes them.
module tb_fetch_queue;
  localparam int DEPTH = 16;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [29:0] instr;
  } ent_t;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  in_cnt = '0;
  logic [59:0] in_instr = '0;
  logic [63:0] in_pc = '0;
  logic        in_ready;
  logic [1:0]  pop_cnt = '0;
  logic [1:0]  out_valid;
  logic [59:0] out_instr;
  logic [63:0] out_pc;
  logic [4:0]  count;
  logic        empty, full, almost_full;

  ent_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] nxt_pc = '0;

  always #5 clock = ~clock;

  fetch_queue dut (
    .clock       (clock),
    .resetn      (resetn),
    .flush       (flush),
    .in_cnt      (in_cnt),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .in_ready    (in_ready),
    .pop_cnt     (pop_cnt),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full)
  );

  function automatic logic [29:0] mk(input logic [31:0] pc);
    return pc[31:2] ^ 30'h2A5A_5A5A;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_in(input int n);
    for (int k = 0; k < n; k++) begin
      sb.push_back({nxt_pc, mk(nxt_pc)});
      nxt_pc = nxt_pc + 32'd4;
    end
  endtask

  // One clock cycle: drive, check combinational outputs, update scoreboard.
  task automatic cycle(input int n_in, input int n_pop, input bit fl);
    int   sz, nv, npop;
    bit   acc, byp;
    ent_t e;
    in_cnt   = 2'(n_in);
    pop_cnt  = 2'(n_pop);
    flush    = fl;
    in_pc    = {nxt_pc + 32'd4, nxt_pc};
    in_instr = {mk(nxt_pc + 32'd4), mk(nxt_pc)};
    #1;
    sz  = sb.size();
    acc = !fl && (n_in <= DEPTH - sz);
    byp = BYP && !fl && (sz == 0);
    check("count", 64'(count), 64'(sz));
    check("empty", 64'(empty), 64'(sz == 0));
    check("full", 64'(full), 64'(sz == DEPTH));
    check("almost_full", 64'(almost_full), 64'(sz >= DEPTH - 2));
    check("in_ready", 64'(in_ready), 64'(DEPTH - sz >= 2));
    if (byp && acc) push_in(n_in);
    nv = (sb.size() > 2) ? 2 : sb.size();
    check("out_valid", 64'(out_valid), 64'((1 << nv) - 1));
    for (int i = nv; i < 2; i++) begin
      check("idle_pc", 64'(out_pc[i*32 +: 32]), 64'd0);
      check("idle_instr", 64'(out_instr[i*30 +: 30]), 64'd0);
    end
    if (fl) begin
      sb.delete();
    end else begin
      npop = (n_pop < nv) ? n_pop : nv;
      for (int i = 0; i < npop; i++) begin
        e = sb.pop_front();
        check("pop_pc", 64'(out_pc[i*32 +: 32]), 64'(e.pc));
        check("pop_instr", 64'(out_instr[i*30 +: 30]), 64'(e.instr));
      end
      if (acc && !byp) push_in(n_in);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    int pushed;
    // Reset values while resetn is held low.
    #2;
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_afull", 64'(almost_full), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_pc", out_pc, 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    #10 resetn = 1'b1;
    @(posedge clock);
    #1;

    // Two-entry push, visible on the next cycle.
    nxt_pc = 32'h100;
    cycle(2, 0, 0);
    check("req039_count", 64'(count), 64'd2);
    check("req039_valid", 64'(out_valid), 64'd3);
    check("req039_pc", out_pc, 64'h0000_0104_0000_0100);
    cycle(0, 2, 0);

    // Fill to full, then push+pop into full is rejected.
    for (int i = 0; i < 8; i++) cycle(2, 0, 0);
    check("fill_full", 64'(full), 64'd1);
    cycle(1, 1, 0);
    check("req040_count", 64'(count), 64'd15);
    check("req040_full", 64'(full), 64'd0);
    check("req040_in_ready", 64'(in_ready), 64'd0);
    cycle(2, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 1, 0);
    for (int i = 0; i < 7; i++) cycle(0, 2, 0);
    // Over-pop with one entry left, then confirm pointers still line up.
    check("req041_pre", 64'(count), 64'd1);
    cycle(0, 2, 0);
    check("req041_count", 64'(count), 64'd0);
    check("req041_empty", 64'(empty), 64'd1);
    cycle(2, 0, 0);
    cycle(0, 2, 0);

    // 40 single pushes/pops with random stalls, wrapping the storage.
    nxt_pc = '0;
    pushed = 0;
    for (int c = 0; c < 1000 && (pushed < 40 || sb.size() > 0); c++) begin
      cycle((pushed < 40 && $urandom_range(0, 2) != 0) ? 1 : 0,
            ($urandom_range(0, 3) != 0) ? 1 : 0, 0);
      pushed = int'(nxt_pc >> 2);
    end
    check("req042_pushed", 64'(pushed), 64'd40);
    check("req042_count", 64'(count), 64'd0);

    // Flush wins over a same-cycle push and pop.
    for (int i = 0; i < 3; i++) cycle(2, 0, 0);
    cycle(1, 0, 0);
    check("req043_pre", 64'(count), 64'd7);
    cycle(2, 2, 1);
    check("req043_count", 64'(count), 64'd0);
    check("req043_empty", 64'(empty), 64'd1);
    check("req043_valid", 64'(out_valid), 64'd0);
    cycle(2, 0, 0);
    cycle(0, 2, 0);

    // Asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 3; i++) cycle(2, 0, 0);
    in_cnt  = '0;
    pop_cnt = '0;
    resetn  = 1'b0;
    #1;
    check("arst_count", 64'(count), 64'd0);
    check("arst_empty", 64'(empty), 64'd1);
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_pc", out_pc, 64'd0);
    sb.delete();
    #2 resetn = 1'b1;
    @(posedge clock);
    #1;
    nxt_pc = 32'h400;
    cycle(2, 0, 0);
    cycle(0, 1, 0);

    // Random mix including occasional flushes.
    for (int c = 0; c < 300; c++)
      cycle($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 39) == 0);
    for (int c = 0; c < 20 && sb.size() > 0; c++) cycle(0, 2, 0);
    check("drain_count", 64'(count), 64'd0);

`ifdef FETCH_QUEUE_BYPASS_EN
    nxt_pc = 32'h200;
    cycle(2, 1, 0);
    check("req044_count", 64'(count), 64'd1);
    check("req044_pc", 64'(out_pc[31:0]), 64'h204);
    cycle(0, 1, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
